pool_flatten_buffer: RTL and testbench
======================================

// Module: pool_flatten_buffer
// PURPOSE
//  Downstream of the pooling layer. Captures each 3-channel pooled sample while ready_pool is high, buffers one
//  full pooled image, then streams it element-by-element in channel-major flatten order (c*POS_NUM+p)
//  to the fully-connected layer over a valid/ready handshake. Decouples pool output timing from FC consumption.
// PARAMETERS
//  CH       3    channels per pooled sample (matches pool lanes, indexed [CH:1])
//  DATA_W   16   signed feature width
//  POS_NUM  169  pooled positions per image (13x13); buffer depth = CH*POS_NUM
// PORTS
//  clk          in   1                  single clock, rising edge
//  n_reset      in   1                  asynchronous, active-low reset
//  start        in   1                  new image: clears write/read pointers, enters FILL
//  ready_pool   in   1                  in_feature valid this cycle (one pooled position)
//  in_feature   in   signed [DATA_W-1:0] [CH:1]  pooled values, lane c = channel c
//  out_data     out  signed [DATA_W-1:0]  flattened element
//  out_valid    out  1                  out_data valid
//  out_ready    in   1                  FC accepts out_data when out_valid & out_ready
//  out_index    out  $clog2(CH*POS_NUM) flatten index of out_data
//  out_last     out  1                  high with final element (index CH*POS_NUM-1)
//  busy         out  1                  high in FILL or DRAIN
//  overflow     out  1                  sticky: ready_pool seen outside FILL, or after POS_NUM captures
// BEHAVIOUR
//  - Reset: state IDLE; all pointers 0; out_data=0, out_valid=0, out_index=0, out_last=0, busy=0, overflow=0.
//  - FSM: IDLE -start-> FILL; FILL -POS_NUM-th capture-> DRAIN; DRAIN -last handshake-> IDLE.
//    start in any state (incl. mid-FILL/DRAIN): pointers to 0, out_valid=0 next cycle, state FILL; overflow kept.
//  - FILL: each cycle with ready_pool=1, lane c written to addr (c-1)*POS_NUM + wr_pos; wr_pos++.
//    Capture of wr_pos=POS_NUM-1 moves to DRAIN next cycle. start and ready_pool same cycle: start wins, sample dropped.
//  - DRAIN: buffer read latency 1 cycle; first out_valid 1 cycle after entering DRAIN.
//    out_data/out_index/out_last hold stable while out_valid & !out_ready. Handshake advances rd_idx;
//    full throughput = 1 element/cycle with out_ready held high (read prefetched).
//    out_last=1 only when out_index=CH*POS_NUM-1; after that handshake out_valid=0, state IDLE.
//  - ready_pool in IDLE or DRAIN: sample ignored, overflow set (sticky until n_reset).
//  - No arithmetic on data except optional clamp; widths preserved, no truncation.
// CONFIGURATION
//  FLATTEN_RELU_EN defined: on write, negative values stored as 0 (ReLU fused before FC).
//  Not defined: values stored and emitted unchanged, negatives pass through.
// STRUCTURE
//  Shared package cnn_pkg: DATA_W, CH localparams, typedef feature_t (logic signed [DATA_W-1:0]),
//  typedef enum {IDLE, FILL, DRAIN} flat_state_t.
//  Sub-module flatten_ram: simple dual-port, CH write lanes x POS_NUM depth per bank (one bank per channel),
//  1 read port, registered read output; top block holds FSM, pointers and output register.
// TESTING
//  1 Reset: n_reset low mid-DRAIN -> all outputs 0, state IDLE immediately (async), no out_valid after release.
//  2 POS_NUM=4: start, 4 ready_pool pulses with lanes {c*10+p} -> stream 10,11,12,13,20,...,33; out_last on index 11.
//  3 Backpressure: out_ready toggles 1,0,0,1 -> out_data/out_index stable during stalls, no element skipped or duplicated.
//  4 Overflow: ready_pool during DRAIN -> overflow=1, stream unaffected; stays 1 after next start.
//  5 Abort: start at index 5 of DRAIN -> out_valid=0 next cycle, busy=1, new fill stored from address 0.
//  6 FLATTEN_RELU_EN: input -7 on lane 2 -> emitted 0; without macro -> emitted -7 (16'hFFF9).

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN definitions used by the pooled-feature flatten buffer.
// Holds the default lane count and feature width, the signed feature type
// and the buffer FSM state encoding.
package cnn_pkg;

    localparam int DATA_W = 16;
    localparam int CH     = 3;

    typedef logic signed [DATA_W-1:0] feature_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } flat_state_t;

endpackage

// File: rtl/flatten_ram.sv
// Image buffer for the flatten stage: one bank per channel, POS_NUM deep.
// All CH lanes are written together at one position. A single read port
// selects bank/position and has a registered output that holds its value
// whenever no read is requested, so it can act directly as the output data
// register during downstream stalls.
module flatten_ram #(
    parameter int CH      = 3,
    parameter int DATA_W  = 16,
    parameter int POS_NUM = 169,
    parameter int POS_W   = 8,
    parameter int BANK_W  = 2
) (
    input  logic                           clk,
    input  logic                           n_reset,
    input  logic                           wr_en_i,
    input  logic [POS_W-1:0]               wr_pos_i,
    input  logic signed [CH:1][DATA_W-1:0] wr_data_i,
    input  logic                           rd_en_i,
    input  logic [BANK_W-1:0]              rd_bank_i,
    input  logic [POS_W-1:0]               rd_pos_i,
    output logic signed [DATA_W-1:0]       rd_data_o
);

    logic [DATA_W-1:0]        mem_q [CH][POS_NUM];
    logic signed [DATA_W-1:0] rd_data_q;

    // Write all channel lanes of one pooled position into their banks.
    // NOTE: the storage array has no reset; every location is written during
    // FILL before DRAIN can read it, and a reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int c = 1; c <= CH; c++) begin
                mem_q[c-1][wr_pos_i] <= wr_data_i[c];
            end
        end
    end

    // Registered read port; holds its last value when no read is issued.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_bank_i][rd_pos_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pool_flatten_buffer.sv
// Pooled-feature flatten buffer: captures one pooled image (CH lanes per
// position), then streams it to the FC layer in channel-major order
// (index = c*POS_NUM + p) over valid/ready with one element per cycle.
// Optional build macro FLATTEN_RELU_EN clamps negative values to zero on write.
module pool_flatten_buffer #(
    parameter int CH      = cnn_pkg::CH,
    parameter int DATA_W  = cnn_pkg::DATA_W,
    parameter int POS_NUM = 169
) (
    input  logic                           clk,
    input  logic                           n_reset,
    input  logic                           start,
    input  logic                           ready_pool,
    input  logic signed [CH:1][DATA_W-1:0] in_feature,
    output logic signed [DATA_W-1:0]       out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(CH*POS_NUM)-1:0]  out_index,
    output logic                           out_last,
    output logic                           busy,
    output logic                           overflow
);

    import cnn_pkg::*;

    localparam int TOTAL  = CH * POS_NUM;
    localparam int IDX_W  = $clog2(TOTAL);
    localparam int POS_W  = (POS_NUM > 1) ? $clog2(POS_NUM) : 1;
    localparam int BANK_W = (CH > 1) ? $clog2(CH) : 1;

    flat_state_t          state_q, state_d;
    logic [POS_W-1:0]     wr_pos_q, wr_pos_d;
    logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
    logic [BANK_W-1:0]    rd_bank_q, rd_bank_d;
    logic [POS_W-1:0]     rd_pos_q, rd_pos_d;
    logic                 fetch_done_q, fetch_done_d;
    logic                 out_valid_q, out_valid_d;
    logic [IDX_W-1:0]     out_index_q, out_index_d;
    logic                 out_last_q, out_last_d;
    logic                 overflow_q, overflow_d;

    logic                           capture;
    logic                           advance;
    logic                           fetch;
    logic signed [CH:1][DATA_W-1:0] wr_lanes;

    // A sample is captured only in FILL; start in the same cycle drops it.
    assign capture = (state_q == FILL) && ready_pool && !start;
    // The output slot can take a new element when empty or being consumed.
    assign advance = !out_valid_q || out_ready;
    // Prefetch the next element into the RAM output register.
    assign fetch   = (state_q == DRAIN) && advance && !fetch_done_q && !start;

    // Write-path conditioning: optional ReLU clamp, otherwise pass-through.
    always_comb begin
        for (int c = 1; c <= CH; c++) begin
`ifdef FLATTEN_RELU_EN
            wr_lanes[c] = in_feature[c][DATA_W-1] ? '0 : in_feature[c];
`else
            wr_lanes[c] = in_feature[c];
`endif
        end
    end

    // Next-state logic for the FSM, pointers and output qualifiers.
    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a signal
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        wr_pos_d     = wr_pos_q;
        rd_idx_d     = rd_idx_q;
        rd_bank_d    = rd_bank_q;
        rd_pos_d     = rd_pos_q;
        fetch_done_d = fetch_done_q;
        out_valid_d  = out_valid_q;
        out_index_d  = out_index_q;
        out_last_d   = out_last_q;
        overflow_d   = overflow_q;

        if (ready_pool && (state_q != FILL)) begin
            overflow_d = 1'b1;
        end

        if (start) begin
            state_d      = FILL;
            wr_pos_d     = '0;
            rd_idx_d     = '0;
            rd_bank_d    = '0;
            rd_pos_d     = '0;
            fetch_done_d = 1'b0;
            out_valid_d  = 1'b0;
            out_index_d  = '0;
            out_last_d   = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (capture) begin
                        if (wr_pos_q == POS_W'(POS_NUM - 1)) begin
                            wr_pos_d = '0;
                            state_d  = DRAIN;
                        end else begin
                            wr_pos_d = wr_pos_q + POS_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (advance) begin
                        out_valid_d = fetch;
                        out_last_d  = fetch && (rd_idx_q == IDX_W'(TOTAL - 1));
                        if (fetch) begin
                            out_index_d = rd_idx_q;
                            rd_idx_d    = rd_idx_q + IDX_W'(1);
                            if (rd_idx_q == IDX_W'(TOTAL - 1)) begin
                                fetch_done_d = 1'b1;
                            end
                            if (rd_pos_q == POS_W'(POS_NUM - 1)) begin
                                rd_pos_d  = '0;
                                rd_bank_d = rd_bank_q + BANK_W'(1);
                            end else begin
                                rd_pos_d = rd_pos_q + POS_W'(1);
                            end
                        end
                    end
                    if (out_valid_q && out_ready && out_last_q) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and pointer registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= IDLE;
            wr_pos_q     <= '0;
            rd_idx_q     <= '0;
            rd_bank_q    <= '0;
            rd_pos_q     <= '0;
            fetch_done_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_pos_q     <= wr_pos_d;
            rd_idx_q     <= rd_idx_d;
            rd_bank_q    <= rd_bank_d;
            rd_pos_q     <= rd_pos_d;
            fetch_done_q <= fetch_done_d;
            out_valid_q  <= out_valid_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
            overflow_q   <= overflow_d;
        end
    end

    flatten_ram #(
        .CH      (CH),
        .DATA_W  (DATA_W),
        .POS_NUM (POS_NUM),
        .POS_W   (POS_W),
        .BANK_W  (BANK_W)
    ) u_ram (
        .clk       (clk),
        .n_reset   (n_reset),
        .wr_en_i   (capture),
        .wr_pos_i  (wr_pos_q),
        .wr_data_i (wr_lanes),
        .rd_en_i   (fetch),
        .rd_bank_i (rd_bank_q),
        .rd_pos_i  (rd_pos_q),
        .rd_data_o (out_data)
    );

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pool_flatten_buffer.sv
// Directed bench for pool_flatten_buffer with POS_NUM=4 (12-element image).
// Image values: lane c, position p -> base + c*10 + p, so the flattened
// stream is base+10,11,12,13,20,...,33.
module tb_pool_flatten_buffer;

    localparam int TOTAL = 12;

    logic                     clk;
    logic                     n_reset;
    logic                     start;
    logic                     ready_pool;
    logic signed [3:1][15:0]  in_feature;
    logic signed [15:0]       out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [3:0]               out_index;
    logic                     out_last;
    logic                     busy;
    logic                     overflow;

    int total = 0;
    int bad   = 0;

    pool_flatten_buffer #(
        .CH      (3),
        .DATA_W  (16),
        .POS_NUM (4)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .start      (start),
        .ready_pool (ready_pool),
        .in_feature (in_feature),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_val(input int base, input bit neg, input int i);
        if (neg && i == 4) begin
`ifdef FLATTEN_RELU_EN
            return 16'h0000;
`else
            return 16'hFFF9;
`endif
        end
        return 16'(base + (i / 4 + 1) * 10 + i % 4);
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_data(input int base, input bit neg);
        for (int p = 0; p < 4; p++) begin
            ready_pool = 1'b1;
            for (int c = 1; c <= 3; c++) in_feature[c] = 16'(base + c * 10 + p);
            if (neg && p == 0) in_feature[2] = 16'hFFF9;
            tick();
        end
        ready_pool = 1'b0;
    endtask

    // mode 0: out_ready held high; mode 1: out_ready cycles 1,0,0,1.
    // stop_at: return once element stop_at is presented (not accepted).
    // ovf_at: cycle on which a stray ready_pool pulse is driven.
    task automatic drain(input int base, input bit neg, input int mode,
                         input int stop_at, input int ovf_at);
        int k = 0;
        bit stalled = 1'b0;
        logic [15:0] sd = '0;
        logic [15:0] si = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            out_ready  = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            ready_pool = (cyc == ovf_at);
            in_feature = {3{16'h7777}};
            if (stalled) begin
                check("stall_valid", 16'(out_valid), 16'd1);
                check("stall_data", out_data, sd);
                check("stall_index", 16'(out_index), si);
            end
            stalled = 1'b0;
            if (out_valid) begin
                if (k == stop_at) begin
                    ready_pool = 1'b0;
                    check("stop_index", 16'(out_index), 16'(stop_at));
                    return;
                end
                if (out_ready) begin
                    check("data", out_data, exp_val(base, neg, k));
                    check("index", 16'(out_index), 16'(k));
                    check("last", 16'(out_last), 16'(k == TOTAL - 1));
                    if (k == TOTAL - 1) begin
                        tick();
                        ready_pool = 1'b0;
                        check("end_valid", 16'(out_valid), 16'd0);
                        check("end_busy", 16'(busy), 16'd0);
                        return;
                    end
                    k++;
                end else begin
                    stalled = 1'b1;
                    sd = out_data;
                    si = 16'(out_index);
                end
            end
            tick();
        end
        ready_pool = 1'b0;
        check("drain_timeout", 16'(k), 16'(TOTAL));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_reset    = 1'b0;
        start      = 1'b0;
        ready_pool = 1'b0;
        out_ready  = 1'b0;
        in_feature = '0;
        #12;
        check("rst_valid", 16'(out_valid), 16'd0);
        check("rst_data", out_data, 16'd0);
        check("rst_index", 16'(out_index), 16'd0);
        check("rst_last", 16'(out_last), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_ovf", 16'(overflow), 16'd0);
        @(negedge clk);
        n_reset = 1'b1;
        tick();

        // Basic fill + full-rate drain.
        pulse_start();
        check("fill_busy", 16'(busy), 16'd1);
        check("fill_valid", 16'(out_valid), 16'd0);
        fill_data(0, 1'b0);
        check("drain_entry_valid", 16'(out_valid), 16'd0);
        check("drain_entry_busy", 16'(busy), 16'd1);
        drain(0, 1'b0, 0, -1, -1);

        // Backpressure with out_ready pattern 1,0,0,1.
        pulse_start();
        fill_data(40, 1'b0);
        drain(40, 1'b0, 1, -1, -1);
        check("no_ovf_yet", 16'(overflow), 16'd0);

        // Stray ready_pool during DRAIN: sticky overflow, stream intact.
        pulse_start();
        fill_data(0, 1'b0);
        drain(0, 1'b0, 0, -1, 2);
        check("ovf_set", 16'(overflow), 16'd1);
        pulse_start();
        check("ovf_kept", 16'(overflow), 16'd1);
        check("ovf_busy", 16'(busy), 16'd1);
        fill_data(0, 1'b0);
        drain(0, 1'b0, 0, -1, -1);

        // Abort at index 5 of DRAIN, refill from address 0.
        pulse_start();
        fill_data(0, 1'b0);
        drain(0, 1'b0, 0, 5, -1);
        start     = 1'b1;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        check("abort_valid", 16'(out_valid), 16'd0);
        check("abort_busy", 16'(busy), 16'd1);
        fill_data(100, 1'b0);
        drain(100, 1'b0, 0, -1, -1);

        // Asynchronous reset in the middle of DRAIN.
        pulse_start();
        fill_data(0, 1'b0);
        drain(0, 1'b0, 0, 3, -1);
        check("pre_rst_valid", 16'(out_valid), 16'd1);
        #2;
        n_reset = 1'b0;
        #1;
        check("async_valid", 16'(out_valid), 16'd0);
        check("async_data", out_data, 16'd0);
        check("async_index", 16'(out_index), 16'd0);
        check("async_last", 16'(out_last), 16'd0);
        check("async_busy", 16'(busy), 16'd0);
        check("async_ovf", 16'(overflow), 16'd0);
        @(negedge clk);
        n_reset   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_valid", 16'(out_valid), 16'd0);
            check("post_rst_busy", 16'(busy), 16'd0);
        end

        // Negative value on lane 2: clamped only with FLATTEN_RELU_EN.
        pulse_start();
        fill_data(0, 1'b1);
        drain(0, 1'b1, 0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
